// File: rtl/fft_pkg.sv
// Shared types and helpers for the in-place radix-2 DIT FFT sequencer.
// Exports the FSM state enum, angle width helper and twiddle-angle function.
package fft_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } fft_seq_state_e;

  // Angle width: one more bit than the butterfly fraction (full turn = 2^bits).
  function automatic int angle_bits(input int frac_bits);
    return frac_bits + 1;
  endfunction

  // Twiddle angle for butterfly j of stage s: j * FULL_TURN / 2^(s+1).
  function automatic int unsigned twiddle_angle(
    input int unsigned j,
    input int unsigned s,
    input int unsigned abits
  );
    return j << (abits - 1 - s);
  endfunction

endpackage

// File: rtl/fft_sequencer_if.sv
// Control/address bundle between the FFT sequencer and its datapath.
// master: sequencer side; slave: memory/butterfly/controller side.
interface fft_sequencer_if #(
  parameter int LOG2N      = 4,
  parameter int ANGLE_BITS = 16
);
  logic                  start_i;
  logic                  busy_o;
  logic                  done_o;
  logic [LOG2N-1:0]      stage_o;
  logic                  rd_en_o;
  logic [LOG2N-1:0]      rd_addr_a_o;
  logic [LOG2N-1:0]      rd_addr_b_o;
  logic [ANGLE_BITS-1:0] twid_o;
  logic                  wr_en_o;
  logic [LOG2N-1:0]      wr_addr_a_o;
  logic [LOG2N-1:0]      wr_addr_b_o;

  modport master (
    input  start_i,
    output busy_o, done_o, stage_o,
    output rd_en_o, rd_addr_a_o, rd_addr_b_o,
    output twid_o,
    output wr_en_o, wr_addr_a_o, wr_addr_b_o
  );

  modport slave (
    output start_i,
    input  busy_o, done_o, stage_o,
    input  rd_en_o, rd_addr_a_o, rd_addr_b_o,
    input  twid_o,
    input  wr_en_o, wr_addr_a_o, wr_addr_b_o
  );
endinterface

// File: rtl/fft_addr_delay.sv
// Fixed-depth shift register with synchronous clear (DEPTH >= 1).
// Ports: clk_i, rst, d_i (WIDTH) in; d_o (WIDTH) = d_i delayed DEPTH cycles.
module fft_addr_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] d_o
);
  logic [WIDTH-1:0] sr_d [DEPTH];
  logic [WIDTH-1:0] sr_q [DEPTH];

  always_comb begin
    sr_d[0] = d_i;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= sr_d[i];
      end
    end
  end

  assign d_o = sr_q[DEPTH-1];
endmodule

// File: rtl/fft_sequencer.sv
// Address/twiddle sequencer for an in-place radix-2 DIT FFT, one butterfly/cycle.
// Ports: clk_i, rst (sync, active-high); bus (fft_sequencer_if.master).
module fft_sequencer #(
  parameter int LOG2N     = 4,
  parameter int FRAC_BITS = 15,
  parameter int RD_LAT    = 1,
  parameter int PIPE_LAT  = 8
) (
  input logic clk_i,
  input logic rst,
  fft_sequencer_if.master bus
);
  import fft_pkg::*;

  localparam int N  = 1 << LOG2N;
  localparam int AB = angle_bits(FRAC_BITS);
  localparam int L  = RD_LAT + PIPE_LAT;
  localparam int CW = $clog2(L + 1);

  typedef logic [LOG2N-1:0] addr_t;
  typedef logic [AB-1:0]    angle_t;
  typedef logic [CW-1:0]    cnt_t;

  localparam addr_t K_LAST = addr_t'(N / 2 - 1);
  localparam addr_t S_LAST = addr_t'(LOG2N - 1);
  localparam cnt_t  C_LAST = cnt_t'(L - 1);

  // Low s bits of k are j; the rest is the group index g.
  function automatic addr_t mask_of(input addr_t s);
    return addr_t'((32'd1 << s) - 32'd1);
  endfunction

  // a = g*2h + j: shift the group bits up by one, keep j.
  function automatic addr_t addr_a_of(input addr_t k, input addr_t s);
    addr_t m;
    m = mask_of(s);
    return ((k & ~m) << 1) | (k & m);
  endfunction

  function automatic angle_t angle_of(input addr_t k, input addr_t s);
    int unsigned v;
    v = twiddle_angle(32'(k & mask_of(s)), 32'(s), AB);
    return angle_t'(v);
  endfunction

  fft_seq_state_e state_d, state_q;
  addr_t  stage_d, stage_q;
  addr_t  k_d, k_q;
  cnt_t   cnt_d, cnt_q;
  logic   rd_en_d, rd_en_q;
  addr_t  rd_a_d, rd_a_q;
  addr_t  rd_b_d, rd_b_q;
  angle_t angle_d, angle_q;
  logic   busy_d, busy_q;
  logic   done_d, done_q;

  logic   load;
  addr_t  ld_k;
  addr_t  ld_s;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    rd_en_d = rd_en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    ld_k    = '0;
    ld_s    = stage_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d = S_ISSUE;
          stage_d = '0;
          k_d     = '0;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
          load    = 1'b1;
          ld_s    = '0;
        end
      end
      S_ISSUE: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          rd_en_d = 1'b0;
        end else begin
          k_d  = k_q + addr_t'(1);
          load = 1'b1;
          ld_k = k_q + addr_t'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q != C_LAST) begin
          cnt_d = cnt_q + cnt_t'(1);
        end else if (stage_q == S_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_ISSUE;
          stage_d = stage_q + addr_t'(1);
          k_d     = '0;
          rd_en_d = 1'b1;
          load    = 1'b1;
          ld_s    = stage_q + addr_t'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Addresses and angle hold between butterflies.
    rd_a_d  = rd_a_q;
    rd_b_d  = rd_b_q;
    angle_d = angle_q;
    if (load) begin
      rd_a_d  = addr_a_of(ld_k, ld_s);
      rd_b_d  = addr_a_of(ld_k, ld_s) | addr_t'(32'd1 << ld_s);
      angle_d = angle_of(ld_k, ld_s);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      angle_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      rd_en_q <= rd_en_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      angle_q <= angle_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Write-back pairs ride alongside the read pair for the full read+butterfly latency.
  logic [2*LOG2N:0] wr_bus;

  fft_addr_delay #(
    .DEPTH (L),
    .WIDTH (2 * LOG2N + 1)
  ) u_wr_dly (
    .clk_i (clk_i),
    .rst   (rst),
    .d_i   ({rd_en_q, rd_a_q, rd_b_q}),
    .d_o   (wr_bus)
  );

  // angle_q holds between issues, so the delayed copy holds too.
  angle_t twid;

  fft_addr_delay #(
    .DEPTH (RD_LAT),
    .WIDTH (AB)
  ) u_tw_dly (
    .clk_i (clk_i),
    .rst   (rst),
    .d_i   (angle_q),
    .d_o   (twid)
  );

  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.stage_o     = stage_q;
  assign bus.rd_en_o     = rd_en_q;
  assign bus.rd_addr_a_o = rd_a_q;
  assign bus.rd_addr_b_o = rd_b_q;
  assign bus.twid_o      = twid;
  assign bus.wr_en_o     = wr_bus[2*LOG2N];
  assign bus.wr_addr_a_o = wr_bus[2*LOG2N-1:LOG2N];
  assign bus.wr_addr_b_o = wr_bus[LOG2N-1:0];
endmodule

// File: tb/tb_fft_sequencer.sv
// Directed, table-driven bench for fft_sequencer (N=16, L=9).
// Records per-cycle output traces, then compares against hand-computed vectors.
module tb_fft_sequencer;
  localparam int NSIG = 10;
  localparam int NCYC = 128;

  localparam int RDEN  = 0;
  localparam int RDA   = 1;
  localparam int RDB   = 2;
  localparam int TW    = 3;
  localparam int WREN  = 4;
  localparam int WRA   = 5;
  localparam int WRB   = 6;
  localparam int BUSY  = 7;
  localparam int DONE  = 8;
  localparam int STAGE = 9;

  typedef struct {
    int run;
    int cyc;
    int sig;
    int exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fft_sequencer_if #(.LOG2N(4), .ANGLE_BITS(16)) bus ();

  fft_sequencer #(
    .LOG2N     (4),
    .FRAC_BITS (15),
    .RD_LAT    (1),
    .PIPE_LAT  (8)
  ) dut (
    .clk_i (clk),
    .rst   (rst),
    .bus   (bus)
  );

  int   tr [2][NSIG][NCYC];
  vec_t vq [$];
  int   n_pass = 0;
  int   n_tot  = 0;

  string nm [NSIG] = '{"rd_en", "rd_a", "rd_b", "twid", "wr_en",
                       "wr_a", "wr_b", "busy", "done", "stage"};

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input int r, input int c, input int s, input int e);
    vq.push_back('{r, c, s, e});
  endtask

  function automatic int sample(input int s);
    case (s)
      RDEN:    return int'(bus.rd_en_o);
      RDA:     return int'(bus.rd_addr_a_o);
      RDB:     return int'(bus.rd_addr_b_o);
      TW:      return int'(bus.twid_o);
      WREN:    return int'(bus.wr_en_o);
      WRA:     return int'(bus.wr_addr_a_o);
      WRB:     return int'(bus.wr_addr_b_o);
      BUSY:    return int'(bus.busy_o);
      DONE:    return int'(bus.done_o);
      default: return int'(bus.stage_o);
    endcase
  endfunction

  // Run 0: start at 0, stray pulse at 20, held high from 60.
  // Run 1: start at 0, reset at 30, restart at 33.
  task automatic run(input int r, input int n);
    for (int c = 0; c < n; c++) begin
      if (r == 0) begin
        bus.start_i = (c == 0) || (c == 20) || (c >= 60);
        rst = 1'b0;
      end else begin
        bus.start_i = (c == 0) || (c == 33);
        rst = (c == 30);
      end
      for (int s = 0; s < NSIG; s++) tr[r][s][c] = sample(s);
      @(posedge clk);
      #1;
    end
    bus.start_i = 1'b0;
    rst = 1'b0;
  endtask

  function automatic int count(input int r, input int s, input int c0, input int c1);
    int n;
    n = 0;
    for (int c = c0; c <= c1; c++) n += tr[r][s][c];
    return n;
  endfunction

  initial begin
    int n_wr;
    int n_busy;

    // Stage 0: pairs (2k, 2k+1) read on 1+k, written on 10+k.
    for (int k = 0; k < 8; k++) begin
      add(0, 1 + k, RDEN, 1);
      add(0, 1 + k, RDA, 2 * k);
      add(0, 1 + k, RDB, 2 * k + 1);
      add(0, 2 + k, TW, 0);
      add(0, 10 + k, WREN, 1);
      add(0, 10 + k, WRA, 2 * k);
      add(0, 10 + k, WRB, 2 * k + 1);
    end
    add(0, 0, RDEN, 0);   add(0, 0, BUSY, 0);
    add(0, 1, BUSY, 1);   add(0, 1, STAGE, 0);
    add(0, 9, RDEN, 0);   add(0, 9, WREN, 0);
    add(0, 17, STAGE, 0); add(0, 18, WREN, 0);
    // Stage 1 (stray start at 20 must not disturb it).
    add(0, 18, STAGE, 1); add(0, 18, RDA, 0); add(0, 18, RDB, 2);
    add(0, 19, RDA, 1);   add(0, 20, RDA, 4); add(0, 20, RDB, 6);
    add(0, 21, RDA, 5);   add(0, 21, RDB, 7);
    add(0, 22, TW, 'h4000);
    add(0, 27, WREN, 1);  add(0, 27, WRA, 0); add(0, 27, WRB, 2);
    // Stage 2.
    add(0, 34, RDEN, 0);  add(0, 34, STAGE, 1);
    add(0, 35, STAGE, 2); add(0, 35, RDA, 0); add(0, 35, RDB, 4);
    add(0, 36, RDA, 1);   add(0, 36, RDB, 5);
    add(0, 38, RDA, 3);   add(0, 38, RDB, 7);
    add(0, 39, RDA, 8);   add(0, 39, RDB, 12);
    add(0, 42, RDA, 11);  add(0, 42, RDB, 15);
    add(0, 36, TW, 'h0000); add(0, 37, TW, 'h2000);
    add(0, 38, TW, 'h4000); add(0, 39, TW, 'h6000);
    add(0, 40, TW, 'h0000); add(0, 41, TW, 'h2000);
    // Stage 3 and completion.
    add(0, 52, STAGE, 3); add(0, 52, RDA, 0); add(0, 52, RDB, 8);
    add(0, 59, RDA, 7);   add(0, 59, RDB, 15);
    add(0, 53, TW, 'h0000); add(0, 54, TW, 'h1000);
    add(0, 60, TW, 'h7000); add(0, 61, TW, 'h7000);
    add(0, 60, RDEN, 0);
    add(0, 61, WREN, 1);  add(0, 61, WRA, 0); add(0, 61, WRB, 8);
    add(0, 68, WREN, 1);  add(0, 68, WRA, 7); add(0, 68, WRB, 15);
    add(0, 69, WREN, 0);
    add(0, 68, BUSY, 1);  add(0, 68, DONE, 0);
    add(0, 69, BUSY, 0);  add(0, 69, DONE, 1);
    add(0, 70, DONE, 0);  add(0, 70, RDEN, 0);
    // Held start: second transform.
    add(0, 71, RDEN, 1);  add(0, 71, RDA, 0); add(0, 71, RDB, 1);
    add(0, 71, STAGE, 0); add(0, 71, BUSY, 1);
    // Reset mid-operation.
    add(1, 30, BUSY, 1);  add(1, 30, STAGE, 1); add(1, 30, TW, 'h4000);
    for (int s = 0; s < NSIG; s++) add(1, 31, s, 0);
    add(1, 33, BUSY, 0);  add(1, 34, WREN, 0);
    add(1, 34, RDEN, 1);  add(1, 34, RDA, 0); add(1, 34, RDB, 1);
    add(1, 34, STAGE, 0); add(1, 35, RDA, 2); add(1, 35, RDB, 3);
    add(1, 43, WREN, 1);  add(1, 43, WRA, 0); add(1, 43, WRB, 1);

    // Reset: 3 cycles, all outputs low, then 20 idle cycles.
    bus.start_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < NSIG; s++) chk({"reset ", nm[s]}, sample(s), 0);
    rst = 1'b0;
    n_wr = 0;
    n_busy = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      n_wr += int'(bus.wr_en_o);
      n_busy += int'(bus.busy_o);
    end
    chk("idle wr_en count", n_wr, 0);
    chk("idle busy count", n_busy, 0);

    run(0, 76);

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    run(1, 50);

    foreach (vq[i]) begin
      chk($sformatf("run%0d cyc%0d %s", vq[i].run, vq[i].cyc, nm[vq[i].sig]),
          tr[vq[i].run][vq[i].sig][vq[i].cyc], vq[i].exp);
    end

    chk("run0 rd_en count 0..70", count(0, RDEN, 0, 70), 32);
    chk("run0 wr_en count 0..70", count(0, WREN, 0, 70), 32);
    chk("run0 busy count 0..70", count(0, BUSY, 0, 70), 68);
    chk("run0 done count 0..70", count(0, DONE, 0, 70), 1);
    chk("run1 wr_en count 31..42", count(1, WREN, 31, 42), 0);
    chk("run1 rd_en count 31..33", count(1, RDEN, 31, 33), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/fft_sequencer.md
# fft_sequencer

Sequencer for an in-place radix-2 decimation-in-time FFT built around one shared `butterfly_cordic` instance and a dual-port complex sample memory. On `start_i` it walks all LOG2N stages, issuing one butterfly per cycle. For each butterfly it drives the memory read-address pair, then a twiddle angle aligned with the returned data, then the write-back address pair once the butterfly result emerges. It drains the pipeline between stages so that no stage reads a location the previous stage has not yet written.

## Interface
- `LOG2N`, 4: log2 of transform size N; 1 ≤ LOG2N ≤ FRAC_BITS+1.
- `FRAC_BITS`, 15: butterfly fraction bits; angle width ANGLE_BITS = FRAC_BITS+1 (full turn = 2^ANGLE_BITS).
- `RD_LAT`, 1: memory read latency, cycles.
- `PIPE_LAT`, 8: butterfly latency, input to `a_o`/`b_o`, cycles.

Ports:
- `clk_i`  in  1  clock; one clock domain.
- `rst`  in  1  synchronous reset, active-high.
- `start_i`  in  1  begin a transform; sampled only in IDLE.
- `busy_o`  out  1  high from the first issue cycle through the final write cycle.
- `done_o`  out  1  one-cycle pulse after the final write.
- `stage_o`  out  LOG2N-width  current stage index s.
- `rd_en_o`  out  1  read strobe for the a/b pair.
- `rd_addr_a_o`, `rd_addr_b_o`  out  LOG2N  read addresses.
- `twid_o`  out  FRAC_BITS+1  unsigned twiddle angle to `butterfly_cordic.twid_i`.
- `wr_en_o`  out  1  write strobe for butterfly outputs.
- `wr_addr_a_o`, `wr_addr_b_o`  out  LOG2N  write addresses for `a_o`/`b_o`.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: `start_i`=1 → ISSUE with s=0, g=0, j=0.
  - ISSUE: one butterfly per cycle for N/2 cycles, then → DRAIN.
  - DRAIN: L = RD_LAT+PIPE_LAT cycles. Afterwards → ISSUE with s+1, or → DONE if s = LOG2N-1.
  - DONE: one cycle, then → IDLE.
- Butterfly indexing in stage s uses h = 2^s. Group g spans 0..N/(2h)-1 and j spans 0..h-1, with j iterating fastest.
  - a = g·2h + j; b = a + h.
  - angle = j << (ANGLE_BITS-1-s), i.e. j·FULL_TURN/(2h), representing W = e^(-j·angle). Unsigned; never wraps, since the maximum is below FULL_TURN/2.
- The input is expected already in bit-reversed order; output is natural order. Reordering is not done here.
- `twid_o` is delayed RD_LAT cycles from the issue cycle so it meets the memory data at the butterfly inputs. It holds its last value when no butterfly is in flight.
- Write addresses travel through an L-deep delay line together with a valid bit; `wr_en_o` is the delayed valid.
- `start_i` is ignored while not in IDLE, including in DONE. Holding `start_i` high starts a new transform on the cycle after DONE.
- `rst` has priority at any point:
  - Next cycle: IDLE, delay line cleared, all outputs 0.
  - No `wr_en_o` is emitted for butterflies in flight at reset.

## Timing
- Reset value of every output is 0.
- `start_i` sampled high at cycle 0 → stage s issues on cycles 1+s·(N/2+L) through s·(N/2+L)+N/2.
- Issue at cycle t → `twid_o` valid at t+RD_LAT; `wr_en_o` with matching addresses at t+L.
- Last write lands at cycle LOG2N·(N/2+L). `done_o` is high at LOG2N·(N/2+L)+1, and `busy_o` is low on that same cycle.
- `stage_o` changes on the first issue cycle of each stage and holds through that stage's DRAIN.
- A read in stage s+1 never precedes the final write of stage s, so read and write never target the same address on the same cycle.

## Structure
- Package `fft_pkg`:
  - state enum `fft_seq_state_e`;
  - `ANGLE_BITS` function of FRAC_BITS;
  - `twiddle_angle(j, s)` function.
- Sub-module `fft_addr_delay`: parameterised-depth shift register carrying {valid, addr_a, addr_b}, with synchronous clear on `rst`. It is reused for the twiddle alignment at depth RD_LAT.

## Test plan
All scenarios use defaults, N=16, L=9.
- Reset: `rst`=1 for 3 cycles → all outputs 0; no `wr_en_o` for 20 idle cycles.
- Stage 0: start at cycle 0 → `rd_en_o` on cycles 1–8 with pairs (0,1),(2,3)…(14,15); `twid_o`=0 on cycles 2–9; `wr_en_o` on cycles 10–17 with the same pairs.
- Stage 2: issue cycles 35–42 → pairs (0,4),(1,5),(2,6),(3,7),(8,12)… with angles 0x0000, 0x2000, 0x4000, 0x6000 repeating.
- Stage 3: issue cycles 52–59 → pairs (0,8)…(7,15) with angles 0x0000, 0x1000 … 0x7000; `done_o` pulses at cycle 69; `busy_o` high on cycles 1–68.
- Start handling: `start_i` pulse at cycle 20 → ignored, schedule unchanged; `start_i` held high → second transform's first read at cycle 71.
- Reset mid-operation: `rst` at cycle 30 → cycle 31 all outputs 0 with no further writes; `start_i` at cycle 33 → first read at cycle 34, stage 0 addressing.
